cacheline_burst_adapter: RTL and testbench

//  Initiator side of the banked DRAM burst interface. Sits between a cache (256-bit line

---
 rtl/cacheline_burst_adapter_if.sv | 31 +++
 rtl/cacheline_burst_adapter.sv | 75 +++++++
 tb/tb_cacheline_burst_adapter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cacheline_burst_adapter_if.sv
// cacheline_burst_adapter_if: cache-line port and banked-memory burst port bundle
interface cacheline_burst_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4
);
  localparam int LINE_W = BEAT_WIDTH * BURST_LEN;
  logic [ADDR_WIDTH-1:0] ufp_addr;
  logic                  ufp_read;
  logic                  ufp_write;
  logic [LINE_W-1:0]     ufp_wdata;
  logic [LINE_W-1:0]     ufp_rdata;
  logic                  ufp_resp;
  logic [ADDR_WIDTH-1:0] dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [BEAT_WIDTH-1:0] dfp_wdata;
  logic                  dfp_ready;
  logic [ADDR_WIDTH-1:0] dfp_raddr;
  logic [BEAT_WIDTH-1:0] dfp_rdata;
  logic                  dfp_rvalid;
  logic                  err;
  modport master (
    input  ufp_addr, ufp_read, ufp_write, ufp_wdata, dfp_ready, dfp_raddr, dfp_rdata, dfp_rvalid,
    output ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata, err
  );
  modport slave (
    output ufp_addr, ufp_read, ufp_write, ufp_wdata, dfp_ready, dfp_raddr, dfp_rdata, dfp_rvalid,
    input  ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata, err
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// cacheline_burst_adapter: 256-bit line read/write to 4x64-bit memory bursts, one transaction in flight.
// Define ADAPTER_RADDR_CHECK_EN to drop read beats whose raddr tag mismatches and raise sticky err.
module cacheline_burst_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BEAT_WIDTH = 64,
  parameter int BURST_LEN  = 4
) (
  input logic clk,
  input logic rst,
  cacheline_burst_adapter_if.master bus
);
  localparam int LINE_W = BEAT_WIDTH * BURST_LEN;
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(LINE_W / 8 - 1);
  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BURST, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] line_addr;
  logic [LINE_W-1:0] line, line_n, rdata;
  logic beat_ok, acc, wr_adv, last;
`ifdef ADAPTER_RADDR_CHECK_EN
  logic err_q;
  assign beat_ok = bus.dfp_raddr == line_addr;
  always_ff @(posedge clk)
    if (rst) err_q <= 1'b0;
    else if (state == RD_DATA && bus.dfp_rvalid && !beat_ok) err_q <= 1'b1;
  assign bus.err = err_q;
`else
  logic unused_raddr;
  assign unused_raddr = ^bus.dfp_raddr;
  assign beat_ok = 1'b1;
  assign bus.err = 1'b0;
`endif
  assign acc    = state == RD_DATA && bus.dfp_rvalid && beat_ok;
  assign wr_adv = state == WR_BURST && bus.dfp_ready;
  assign last   = cnt == CW'(BURST_LEN - 1);
  // the line buffer holds write data for writes and collects beats for reads
  always_comb begin
    line_n = line;
    if (acc) line_n[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH] = bus.dfp_rdata;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = bus.ufp_write ? WR_BURST : bus.ufp_read ? RD_CMD : IDLE;
      RD_CMD:   state_n = bus.dfp_ready ? RD_DATA : RD_CMD;
      RD_DATA:  state_n = acc && last ? DONE : RD_DATA;
      WR_BURST: state_n = wr_adv && last ? DONE : WR_BURST;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_addr <= '0;
      line      <= '0;
      rdata     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && (bus.ufp_read || bus.ufp_write)) begin
        line_addr <= bus.ufp_addr & ~OFS_MASK;
        line      <= bus.ufp_wdata;
      end else line <= line_n;
      if (acc || wr_adv) cnt <= cnt + CW'(1);
      if (acc && last) rdata <= line_n;
    end
  end
  assign bus.dfp_read  = state == RD_CMD;
  assign bus.dfp_write = state == WR_BURST;
  assign bus.dfp_addr  = line_addr;
  assign bus.dfp_wdata = line[int'(cnt)*BEAT_WIDTH +: BEAT_WIDTH];
  assign bus.ufp_resp  = state == DONE;
  assign bus.ufp_rdata = rdata;
endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// tb_cacheline_burst_adapter: directed scoreboard bench for cacheline_burst_adapter
module tb_cacheline_burst_adapter;
  logic clk = 1'b0, rst = 1'b1;
  cacheline_burst_adapter_if bus();
  cacheline_burst_adapter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {bit rd; logic [255:0] line;} exp_t;
  exp_t rq[$];
  logic [63:0] wq[$];
  int tests = 0, fails = 0, cycle = 0, nread = 0, nwrite = 0, nresp = 0, resp_cyc = 0;
  logic [31:0] exp_addr = '0;
  logic [255:0] l1, l3, l4, l7, w1, w2;
  int r0;
  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // one clock: sample at negedge, score outputs, then step past the next posedge
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    cycle++;
    chk("rd_wr_excl", {255'b0, bus.dfp_read & bus.dfp_write}, '0);
    if (bus.dfp_read) begin
      nread++;
      chk("rd_addr", bus.dfp_addr, exp_addr);
    end
    if (bus.dfp_write) begin
      nwrite++;
      chk("wr_addr", bus.dfp_addr, exp_addr);
      chk("wq_nonempty", {255'b0, wq.size() != 0}, 1);
      if (wq.size() != 0) chk("wdata", bus.dfp_wdata, wq.pop_front());
    end
    if (bus.ufp_resp) begin
      nresp++;
      resp_cyc = cycle;
      bus.ufp_read = 1'b0;
      bus.ufp_write = 1'b0;
      chk("rq_nonempty", {255'b0, rq.size() != 0}, 1);
      if (rq.size() != 0) begin
        e = rq.pop_front();
        if (e.rd) chk("rdata", bus.ufp_rdata, e.line);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic wait_resp(input int start);
    int k = 0;
    while (nresp == start && k < 20) begin
      cyc();
      k++;
    end
    chk("resp_seen", nresp - start, 1);
  endtask
  task automatic rd(input logic [31:0] a, input logic [255:0] line, input int gap, input int stall, input int bad);
    int s, rc0, reqc;
    s = nresp;
    rc0 = nread;
    exp_addr = a & ~32'h1f;
    rq.push_back('{1'b1, line});
    bus.ufp_addr = a;
    bus.ufp_read = 1'b1;
    bus.dfp_ready = stall == 0;
    bus.dfp_rvalid = 1'b0;
    cyc();
    reqc = cycle;
    bus.dfp_rvalid = 1'b1;
    bus.dfp_raddr = exp_addr;
    bus.dfp_rdata = 64'hbad0_bad0_bad0_bad0;
    for (int i = 0; i < stall; i++) cyc();
    bus.dfp_ready = 1'b1;
    cyc();
    for (int b = 0; b < 4; b++) begin
      bus.dfp_rvalid = 1'b0;
      for (int g = 0; g < gap; g++) cyc();
      if (b == bad) begin
        bus.dfp_rvalid = 1'b1;
        bus.dfp_raddr = exp_addr + 32'h20;
        bus.dfp_rdata = ~line[b*64 +: 64];
        cyc();
      end
      bus.dfp_rvalid = 1'b1;
      bus.dfp_raddr = exp_addr;
      bus.dfp_rdata = line[b*64 +: 64];
      cyc();
    end
    bus.dfp_rvalid = 1'b0;
    wait_resp(s);
    chk("rd_latency", resp_cyc - reqc, stall + 1 + 4 * (gap + 1) + (bad >= 0 ? 1 : 0) + 1);
    chk("rd_cmd_cycles", nread - rc0, stall + 1);
  endtask
  task automatic wr(input logic [31:0] a, input logic [255:0] line, input int stall_at, input bit both);
    int s, w0, rc0, b;
    s = nresp;
    w0 = nwrite;
    rc0 = nread;
    exp_addr = a & ~32'h1f;
    rq.push_back('{1'b0, line});
    b = 0;
    for (int i = 0; b < 4; i++) begin
      wq.push_back(line[b*64 +: 64]);
      if (i != stall_at) b++;
    end
    bus.ufp_addr = a;
    bus.ufp_write = 1'b1;
    bus.ufp_read = both;
    bus.ufp_wdata = line;
    bus.dfp_ready = 1'b1;
    cyc();
    b = 0;
    for (int i = 0; b < 4 && i < 20; i++) begin
      bus.dfp_ready = i != stall_at;
      cyc();
      if (bus.dfp_ready) b++;
    end
    bus.dfp_ready = 1'b1;
    wait_resp(s);
    chk("wr_beats", nwrite - w0, stall_at >= 0 ? 5 : 4);
    chk("wr_no_read", nread - rc0, 0);
    chk("wq_drained", wq.size(), 0);
  endtask
  initial begin
    bus.ufp_addr = '0;
    bus.ufp_read = 1'b0;
    bus.ufp_write = 1'b0;
    bus.ufp_wdata = '0;
    bus.dfp_ready = 1'b0;
    bus.dfp_raddr = '0;
    bus.dfp_rdata = '0;
    bus.dfp_rvalid = 1'b0;
    l1 = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    w1 = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002, 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};
    l3 = {64'h3333_cccc_0000_0003, 64'h3333_cccc_0000_0002, 64'h3333_cccc_0000_0001, 64'h3333_cccc_0000_0000};
    l4 = {64'h4444_0123_4567_89ab, 64'h4444_fedc_ba98_7654, 64'h4444_0f0f_0f0f_0f0f, 64'h4444_f0f0_f0f0_f0f0};
    w2 = {64'h5555_aaaa_5555_aaaa, 64'hffff_0000_ffff_0000, 64'h0000_ffff_0000_ffff, 64'h1234_5678_9abc_def0};
    l7 = {64'h7007_0000_0000_00d3, 64'h7007_0000_0000_00d2, 64'h7007_0000_0000_00d1, 64'h7007_0000_0000_00d0};
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_dfp_read", bus.dfp_read, 0);
    chk("rst_dfp_write", bus.dfp_write, 0);
    chk("rst_ufp_resp", bus.ufp_resp, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_dfp_addr", bus.dfp_addr, 0);
    chk("rst_dfp_wdata", bus.dfp_wdata, 0);
    chk("rst_ufp_rdata", bus.ufp_rdata, 0);
    rd(32'h1000_0044, l1, 0, 0, -1);
    wr(32'h2000_0000, w1, 1, 1'b0);
    chk("rdata_hold", bus.ufp_rdata, l1);
    rd(32'h3000_0080, l3, 2, 0, -1);
    rd(32'h4000_001f, l4, 0, 3, -1);
    wr(32'h5000_0010, w2, -1, 1'b1);
    r0 = nresp;
    exp_addr = 32'h6000_0000;
    bus.ufp_addr = 32'h6000_0000;
    bus.ufp_read = 1'b1;
    bus.dfp_ready = 1'b1;
    cyc();
    cyc();
    bus.dfp_rvalid = 1'b1;
    bus.dfp_raddr = exp_addr;
    bus.dfp_rdata = 64'h6666_0000_0000_0000;
    cyc();
    cyc();
    bus.dfp_rvalid = 1'b0;
    rst = 1'b1;
    bus.ufp_read = 1'b0;
    cyc();
    rst = 1'b0;
    bus.dfp_rvalid = 1'b1;
    bus.dfp_rdata = 64'hbeef_beef_beef_beef;
    cyc();
    bus.dfp_rvalid = 1'b0;
    cyc();
    cyc();
    chk("abort_no_resp", nresp - r0, 0);
    chk("abort_idle_read", bus.dfp_read, 0);
    rd(32'h7000_0040, l7, 1, 0, -1);
`ifdef ADAPTER_RADDR_CHECK_EN
    chk("err_clear", bus.err, 0);
    rd(32'h1000_0040, l3 ^ l4, 0, 0, 2);
    chk("err_set", bus.err, 1);
`else
    chk("err_tied", bus.err, 0);
`endif
    chk("rq_drained", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
